assoc_cache: RTL and testbench

Parametrised N-way set-associative, write-through, write-allocate data cache between the CPU load/store unit and block-wide main memory. It generalises the fixed 4-way/8-set data cache in ways, sets and block size, and uses tree-PLRU replacement. It handles byte, half and word loads (signed and unsigned) and byte-enable store merging. It uses a valid/ready handshake on both sides.

---
 rtl/assoc_cache.sv | 314 +++++++++++++++++++++++++++++++
 tb/tb_assoc_cache.sv | 369 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : assoc_cache
// Description : N-way set-associative, write-through, write-allocate data
//               cache with tree-PLRU replacement. Serves byte/half/word loads
//               (sign- or zero-extended) and byte-enable stores. Valid/ready
//               handshakes on both the CPU side and the block-wide memory side.
// Ports       : clk, rst_n (async, active-low)
//               cpu_valid_i/cpu_wen_i/cpu_addr_i/cpu_funct3_i/cpu_wdata_i  - request
//               cpu_rdata_o/cpu_ready_o                                    - completion
//               mem_valid_o/mem_wen_o/mem_addr_o/mem_wdata_o               - line request
//               mem_ready_i/mem_rdata_i                                    - line response
//               hit_cnt_o/miss_cnt_o (only when CACHE_PERF_EN is defined)
// Options     : `define CACHE_PERF_EN adds first-lookup hit/miss counters.
// Revision    : 1.0 - initial release
// ============================================================================
module assoc_cache #(
  parameter int  WAYS       = 4,   // power of 2, >= 2
  parameter int  SETS       = 8,   // power of 2, >= 2
  parameter int  BLOCKBYTES = 16,  // power of 2, >= 4
  parameter int  ADDRW      = 32,
  localparam int BLOCKBITS  = 8 * BLOCKBYTES
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 cpu_valid_i,
  input  logic                 cpu_wen_i,
  input  logic [ADDRW-1:0]     cpu_addr_i,
  input  logic [2:0]           cpu_funct3_i,
  input  logic [31:0]          cpu_wdata_i,
  output logic [31:0]          cpu_rdata_o,
  output logic                 cpu_ready_o,
  output logic                 mem_valid_o,
  output logic                 mem_wen_o,
  output logic [ADDRW-1:0]     mem_addr_o,
  output logic [BLOCKBITS-1:0] mem_wdata_o,
  input  logic                 mem_ready_i,
  input  logic [BLOCKBITS-1:0] mem_rdata_i
`ifdef CACHE_PERF_EN
  ,
  output logic [31:0]          hit_cnt_o,
  output logic [31:0]          miss_cnt_o
`endif
);

  localparam int OFFW = $clog2(BLOCKBYTES);
  localparam int IDXW = $clog2(SETS);
  localparam int TAGW = ADDRW - IDXW - OFFW;
  localparam int WAYW = $clog2(WAYS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COMP  = 2'd1,
    S_FILL  = 2'd2,
    S_WTHRU = 2'd3
  } state_t;

  state_t r_state, w_next;

  // Cache storage. Only valid and PLRU bits need a reset value.
  logic [WAYS-1:0]      r_valid [SETS];
  logic [WAYS-2:0]      r_plru  [SETS];
  logic [TAGW-1:0]      r_tag   [SETS][WAYS];
  logic [BLOCKBITS-1:0] r_data  [SETS][WAYS];

  // Latched request
  logic [ADDRW-1:0]     r_addr;
  logic                 r_wen;
  logic [2:0]           r_funct3;
  logic [31:0]          r_wdata;
  logic [BLOCKBITS-1:0] r_wline;   // merged line presented during write-through
  logic                 r_first;   // high until the first lookup of a request

  logic [TAGW-1:0]      w_tag;
  logic [IDXW-1:0]      w_idx;
  logic [OFFW-1:0]      w_off;
  logic [ADDRW-1:0]     w_blk_addr;

  logic                 w_hit;
  logic [WAYW-1:0]      w_hit_way;
  logic                 w_inv_found;
  logic [WAYW-1:0]      w_inv_way;
  logic [WAYW:0]        w_node;
  logic [WAYW-1:0]      w_tree_way;
  logic [WAYW-1:0]      w_victim;
  logic [WAYS-2:0]      w_plru_new;
  logic [WAYW:0]        w_unode;
  logic [WAYW-1:0]      w_path;
  logic                 w_dir;

  logic [BLOCKBITS-1:0] w_line;
  logic [OFFW+2:0]      w_word_sh;
  logic [31:0]          w_word;
  logic [7:0]           w_byte;
  logic [15:0]          w_half;
  logic [31:0]          w_rdata;

  logic [OFFW-1:0]      w_st_off;
  logic [31:0]          w_st_mask32;
  logic [BLOCKBITS-1:0] w_st_mask;
  logic [BLOCKBITS-1:0] w_st_data;
  logic [BLOCKBITS-1:0] w_merged;

  assign w_tag      = r_addr[ADDRW-1 -: TAGW];
  assign w_idx      = r_addr[OFFW +: IDXW];
  assign w_off      = r_addr[OFFW-1:0];
  assign w_blk_addr = {r_addr[ADDRW-1:OFFW], {OFFW{1'b0}}};

  // Parallel tag compare across the set
  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (r_valid[w_idx][WAYW'(w)] && (r_tag[w_idx][WAYW'(w)] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = WAYW'(w);
      end
    end
  end

  // Lowest-index invalid way: scan downwards so the lowest match wins.
  always_comb begin
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!r_valid[w_idx][WAYW'(w)]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAYW'(w);
      end
    end
  end

  // PLRU tree walk. Nodes are heap-numbered from 1; node n lives in bit n-1.
  // After WAYW steps the node number is WAYS + way, so its low bits are the way.
  always_comb begin
    w_node = (WAYW+1)'(1);
    for (int l = 0; l < WAYW; l++) begin
      w_node = {w_node[WAYW-1:0], r_plru[w_idx][WAYW'(w_node - (WAYW+1)'(1))]};
    end
    w_tree_way = w_node[WAYW-1:0];
  end

  assign w_victim = w_inv_found ? w_inv_way : w_tree_way;

  // PLRU update: each node on the hit way's path points to the other half.
  always_comb begin
    w_plru_new = r_plru[w_idx];
    w_unode    = (WAYW+1)'(1);
    w_path     = w_hit_way;
    w_dir      = 1'b0;
    for (int l = 0; l < WAYW; l++) begin
      w_dir  = w_path[WAYW-1];
      w_path = w_path << 1;
      w_plru_new[WAYW'(w_unode - (WAYW+1)'(1))] = ~w_dir;
      w_unode = {w_unode[WAYW-1:0], w_dir};
    end
  end

  // Load extraction; misaligned halves/words are aligned down.
  assign w_line    = r_data[w_idx][w_hit_way];
  assign w_word_sh = {w_off & ~OFFW'(3), 3'b000};
  assign w_word    = 32'(w_line >> w_word_sh);
  assign w_byte    = 8'(w_word >> {w_off[1:0], 3'b000});
  assign w_half    = 16'(w_word >> {w_off[1], 4'b0000});

  always_comb begin
    case (r_funct3[1:0])
      2'b00:   w_rdata = r_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_rdata = r_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_rdata = w_word;
    endcase
  end

  // Store merge: byte mask shifted to the aligned offset
  always_comb begin
    case (r_funct3[1:0])
      2'b00: begin
        w_st_off    = w_off;
        w_st_mask32 = 32'h0000_00FF;
      end
      2'b01: begin
        w_st_off    = w_off & ~OFFW'(1);
        w_st_mask32 = 32'h0000_FFFF;
      end
      default: begin
        w_st_off    = w_off & ~OFFW'(3);
        w_st_mask32 = 32'hFFFF_FFFF;
      end
    endcase
  end

  assign w_st_mask = BLOCKBITS'(w_st_mask32) << {w_st_off, 3'b000};
  assign w_st_data = BLOCKBITS'(r_wdata) << {w_st_off, 3'b000};
  assign w_merged  = (w_line & ~w_st_mask) | (w_st_data & w_st_mask);

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // FSM next state and outputs; everything is 0 outside the driving state.
  always_comb begin
    w_next      = r_state;
    cpu_ready_o = 1'b0;
    cpu_rdata_o = '0;
    mem_valid_o = 1'b0;
    mem_wen_o   = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (r_state)
      S_IDLE: begin
        if (cpu_valid_i) w_next = S_COMP;
      end
      S_COMP: begin
        if (w_hit) begin
          if (r_wen) begin
            w_next = S_WTHRU;
          end else begin
            cpu_ready_o = 1'b1;
            cpu_rdata_o = w_rdata;
            w_next      = S_IDLE;
          end
        end else begin
          w_next = S_FILL;
        end
      end
      S_FILL: begin
        mem_valid_o = 1'b1;
        mem_addr_o  = w_blk_addr;
        if (mem_ready_i) w_next = S_COMP;
      end
      S_WTHRU: begin
        mem_valid_o = 1'b1;
        mem_wen_o   = 1'b1;
        mem_addr_o  = w_blk_addr;
        mem_wdata_o = r_wline;
        if (mem_ready_i) begin
          cpu_ready_o = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Request latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr   <= '0;
      r_wen    <= 1'b0;
      r_funct3 <= '0;
      r_wdata  <= '0;
      r_wline  <= '0;
      r_first  <= 1'b0;
    end else begin
      if (r_state == S_IDLE && cpu_valid_i) begin
        r_addr   <= cpu_addr_i;
        r_wen    <= cpu_wen_i;
        r_funct3 <= cpu_funct3_i;
        r_wdata  <= cpu_wdata_i;
        r_first  <= 1'b1;
      end
      if (r_state == S_COMP) begin
        r_first <= 1'b0;
        if (w_hit && r_wen) r_wline <= w_merged;
      end
    end
  end

  // Valid and PLRU state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        r_plru[s]  <= '0;
      end
    end else begin
      if (r_state == S_FILL && mem_ready_i) r_valid[w_idx][w_victim] <= 1'b1;
      if (r_state == S_COMP && w_hit)       r_plru[w_idx] <= w_plru_new;
    end
  end

  // Tag and data arrays; contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (r_state == S_FILL && mem_ready_i) begin
      r_data[w_idx][w_victim] <= mem_rdata_i;
      r_tag[w_idx][w_victim]  <= w_tag;
    end else if (r_state == S_COMP && w_hit && r_wen) begin
      r_data[w_idx][w_hit_way] <= w_merged;
    end
  end

`ifdef CACHE_PERF_EN
  // Only the first lookup of each request counts; the post-fill re-lookup does not.
  logic [31:0] r_hit_cnt;
  logic [31:0] r_miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else if (r_state == S_COMP && r_first) begin
      if (w_hit) r_hit_cnt  <= r_hit_cnt + 32'd1;
      else       r_miss_cnt <= r_miss_cnt + 32'd1;
    end
  end

  assign hit_cnt_o  = r_hit_cnt;
  assign miss_cnt_o = r_miss_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_assoc_cache.sv
`default_nettype none
// ============================================================================
// Module      : tb_assoc_cache
// Description : Self-checking bench for assoc_cache (default parameters).
//               Line-wide memory responder with programmable wait cycles,
//               reference memory model for expected load data and written
//               lines, expected-result queue popped on cpu_ready_o.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_assoc_cache;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         cpu_valid_i;
  logic         cpu_wen_i;
  logic [31:0]  cpu_addr_i;
  logic [2:0]   cpu_funct3_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_ready_o;
  logic         mem_valid_o;
  logic         mem_wen_o;
  logic [31:0]  mem_addr_o;
  logic [127:0] mem_wdata_o;
  logic         mem_ready_i;
  logic [127:0] mem_rdata_i;
`ifdef CACHE_PERF_EN
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;
`endif

  assoc_cache dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_valid_i  (cpu_valid_i),
    .cpu_wen_i    (cpu_wen_i),
    .cpu_addr_i   (cpu_addr_i),
    .cpu_funct3_i (cpu_funct3_i),
    .cpu_wdata_i  (cpu_wdata_i),
    .cpu_rdata_o  (cpu_rdata_o),
    .cpu_ready_o  (cpu_ready_o),
    .mem_valid_o  (mem_valid_o),
    .mem_wen_o    (mem_wen_o),
    .mem_addr_o   (mem_addr_o),
    .mem_wdata_o  (mem_wdata_o),
    .mem_ready_i  (mem_ready_i),
    .mem_rdata_i  (mem_rdata_i)
`ifdef CACHE_PERF_EN
    ,
    .hit_cnt_o    (hit_cnt),
    .miss_cnt_o   (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_bad = 0;

  logic [127:0] mem_m [logic [31:0]];  // memory seen by the DUT
  logic [127:0] ref_m [logic [31:0]];  // reference contents
  logic [31:0]  sb_q [$];

  int           mem_delay = 0;
  int           wcnt = 0;
  int           rd_cnt = 0;
  int           wr_cnt = 0;
  int           fill_cyc = 0;
  int           hs_err = 0;
  logic [31:0]  last_raddr = '0;
  logic [31:0]  last_waddr = '0;
  logic [127:0] last_wline = '0;

  task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [127:0] dflt_line(input logic [31:0] a);
    return {a + 32'd12, a + 32'd8, a + 32'd4, a} ^ {4{32'h5A5A_0000}};
  endfunction

  function automatic logic [127:0] mem_get(input logic [31:0] a);
    if (mem_m.exists(a)) return mem_m[a];
    return dflt_line(a);
  endfunction

  function automatic logic [127:0] ref_get(input logic [31:0] a);
    if (ref_m.exists(a)) return ref_m[a];
    return dflt_line(a);
  endfunction

  task automatic set_line(input logic [31:0] a, input logic [127:0] l);
    mem_m[a] = l;
    ref_m[a] = l;
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] addr, input logic [2:0] f3);
    logic [127:0] ln;
    int           off;
    int           n;
    logic [31:0]  v;
    ln  = ref_get({addr[31:4], 4'b0000});
    off = int'(addr[3:0]);
    case (f3[1:0])
      2'b00:   n = 1;
      2'b01:   begin n = 2; off = off - (off % 2); end
      default: begin n = 4; off = off - (off % 4); end
    endcase
    v = '0;
    for (int i = 0; i < n; i++) v[i*8 +: 8] = ln[(off+i)*8 +: 8];
    if (!f3[2] && n < 4)
      for (int i = n * 8; i < 32; i++) v[i] = v[n*8-1];
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
    logic [127:0] ln;
    int           off;
    int           n;
    ln  = ref_get({addr[31:4], 4'b0000});
    off = int'(addr[3:0]);
    case (f3[1:0])
      2'b00:   n = 1;
      2'b01:   begin n = 2; off = off - (off % 2); end
      default: begin n = 4; off = off - (off % 4); end
    endcase
    for (int i = 0; i < n; i++) ln[(off+i)*8 +: 8] = wd[i*8 +: 8];
    ref_m[{addr[31:4], 4'b0000}] = ln;
  endtask

  // Memory responder: ready offered after mem_delay waiting cycles.
  initial begin
    mem_ready_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ready_i = 1'b0;
      if (rst_n && mem_valid_o) begin
        if (wcnt == mem_delay) begin
          wcnt        = 0;
          mem_ready_i = 1'b1;
          if (mem_wen_o) begin
            mem_m[mem_addr_o] = mem_wdata_o;
            last_waddr        = mem_addr_o;
            last_wline        = mem_wdata_o;
            wr_cnt++;
          end else begin
            mem_rdata_i = mem_get(mem_addr_o);
            last_raddr  = mem_addr_o;
            rd_cnt++;
          end
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Handshake / output-quiet monitor
  initial begin
    logic         p_valid;
    logic         p_acc;
    logic         p_wen;
    logic [31:0]  p_addr;
    logic [127:0] p_wdata;
    p_valid = 1'b0;
    p_acc   = 1'b0;
    p_wen   = 1'b0;
    p_addr  = '0;
    p_wdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        p_valid = 1'b0;
        p_acc   = 1'b0;
      end else begin
        if (mem_valid_o && p_acc) hs_err++;
        if (mem_valid_o && p_valid && !p_acc &&
            (mem_addr_o !== p_addr || mem_wdata_o !== p_wdata || mem_wen_o !== p_wen)) hs_err++;
        if (!cpu_ready_o && cpu_rdata_o !== 32'd0) hs_err++;
        if (mem_valid_o && !mem_wen_o && cpu_ready_o) hs_err++;
        if (mem_valid_o && !mem_wen_o) fill_cyc++;
        p_valid = mem_valid_o;
        p_acc   = mem_valid_o && mem_ready_i;
        p_wen   = mem_wen_o;
        p_addr  = mem_addr_o;
        p_wdata = mem_wdata_o;
      end
    end
  end

  // One request; latency counted in negedges after the drive point.
  task automatic do_req(input logic wen, input logic [31:0] addr, input logic [2:0] f3,
                        input logic [31:0] wd, input int exp_lat);
    int          cyc;
    logic        done;
    logic [31:0] exp_v;
    if (wen) begin
      ref_store(addr, f3, wd);
      sb_q.push_back(32'd0);
    end else begin
      sb_q.push_back(ref_load(addr, f3));
    end
    @(posedge clk);
    #1;
    cpu_valid_i  = 1'b1;
    cpu_wen_i    = wen;
    cpu_addr_i   = addr;
    cpu_funct3_i = f3;
    cpu_wdata_i  = wd;
    cyc  = 0;
    done = 1'b0;
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 2) cpu_valid_i = 1'b0;
      if (cpu_ready_o) begin
        done  = 1'b1;
        exp_v = sb_q.pop_front();
        check_val($sformatf("rdata@%0h", addr), cpu_rdata_o, exp_v);
        check_val($sformatf("latency@%0h", addr), cyc, exp_lat);
      end
    end
    if (!done) begin
      check_val($sformatf("timeout@%0h", addr), done, 1'b1);
      void'(sb_q.pop_front());
      cpu_valid_i = 1'b0;
    end
  endtask

  task automatic do_reset();
    cpu_valid_i = 1'b0;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int base;
    cpu_valid_i  = 1'b0;
    cpu_wen_i    = 1'b0;
    cpu_addr_i   = '0;
    cpu_funct3_i = '0;
    cpu_wdata_i  = '0;
    rst_n        = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    check_val("rst_ready", cpu_ready_o, 1'b0);
    check_val("rst_rdata", cpu_rdata_o, 32'd0);
    check_val("rst_mvalid", mem_valid_o, 1'b0);
    check_val("rst_maddr", mem_addr_o, 32'd0);
    #2;
    rst_n = 1'b1;

    // Miss then hit on 0x100
    set_line(32'h100, {96'h0123_4567_89AB_CDEF_0F1E_2D3C, 32'hDEAD_BEEF});
    base = rd_cnt;
    do_req(1'b0, 32'h100, 3'b010, 32'd0, 4);
    check_val("fill_addr", last_raddr, 32'h100);
    check_val("fill_cnt", rd_cnt - base, 1);
    do_req(1'b0, 32'h100, 3'b010, 32'd0, 2);
    check_val("hit_nomem", rd_cnt - base, 1);

    // Sub-word loads
    do_reset();
    set_line(32'h100, {96'h1122_3344_5566_7788_99AA_BBCC, 32'h8012_0000});
    do_req(1'b0, 32'h103, 3'b000, 32'd0, 4);   // LB  -> FFFFFF80
    do_req(1'b0, 32'h103, 3'b100, 32'd0, 2);   // LBU -> 00000080
    do_req(1'b0, 32'h103, 3'b001, 32'd0, 2);   // LH  -> FFFF8012
    do_req(1'b0, 32'h102, 3'b101, 32'd0, 2);   // LHU -> 00008012
    do_req(1'b0, 32'h10E, 3'b000, 32'd0, 2);
    do_req(1'b0, 32'h10B, 3'b001, 32'd0, 2);
    do_req(1'b0, 32'h10F, 3'b010, 32'd0, 2);

    // Stores: write-allocate miss, then write hits
    do_reset();
    set_line(32'h100, 128'd0);
    base = wr_cnt;
    do_req(1'b1, 32'h105, 3'b000, 32'hFFFF_FF5A, 5);
    check_val("sb_wcnt", wr_cnt - base, 1);
    check_val("sb_waddr", last_waddr, 32'h100);
    check_val("sb_wline", last_wline, ref_get(32'h100));
    do_req(1'b0, 32'h104, 3'b010, 32'd0, 2);   // 00005A00
    do_req(1'b1, 32'h10B, 3'b001, 32'h1234_BEEF, 3);
    check_val("sh_wline", last_wline, ref_get(32'h100));
    do_req(1'b1, 32'h10F, 3'b010, 32'h1234_5678, 3);
    check_val("sw_wline", last_wline, ref_get(32'h100));
    check_val("st_wcnt", wr_cnt - base, 3);
    do_req(1'b0, 32'h108, 3'b010, 32'd0, 2);
    do_req(1'b0, 32'h10C, 3'b010, 32'd0, 2);
    do_req(1'b0, 32'h10A, 3'b101, 32'd0, 2);

    // PLRU replacement in set 0
    do_reset();
    base = rd_cnt;
    for (int i = 0; i < 5; i++) do_req(1'b0, 32'h80 * i, 3'b010, 32'd0, 4);
    check_val("plru_fills", rd_cnt - base, 5);
    do_req(1'b0, 32'h080, 3'b010, 32'd0, 2);
    check_val("plru_080_hit", rd_cnt - base, 5);
    do_req(1'b0, 32'h000, 3'b010, 32'd0, 4);
    check_val("plru_000_miss", rd_cnt - base, 6);

    // Slow memory: 10 wait cycles in FILL
    do_reset();
    mem_delay = 10;
    base = fill_cyc;
    do_req(1'b0, 32'h300, 3'b010, 32'd0, 14);
    check_val("slow_fill_cycles", fill_cyc - base, 11);

    // Reset while in FILL
    do_reset();
    @(posedge clk);
    #1;
    cpu_valid_i  = 1'b1;
    cpu_wen_i    = 1'b0;
    cpu_addr_i   = 32'h400;
    cpu_funct3_i = 3'b010;
    @(negedge clk);
    @(negedge clk);
    cpu_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check_val("midfill_busy", mem_valid_o, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("midfill_mvalid", mem_valid_o, 1'b0);
    check_val("midfill_maddr", mem_addr_o, 32'd0);
    check_val("midfill_ready", cpu_ready_o, 1'b0);
    check_val("midfill_rdata", cpu_rdata_o, 32'd0);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    mem_delay = 0;
    base = rd_cnt;
    do_req(1'b0, 32'h400, 3'b010, 32'd0, 4);
    check_val("after_rst_miss", rd_cnt - base, 1);
    do_req(1'b0, 32'h400, 3'b010, 32'd0, 2);
`ifdef CACHE_PERF_EN
    check_val("perf_hit", hit_cnt, 32'd1);
    check_val("perf_miss", miss_cnt, 32'd1);
`endif

    repeat (2) @(negedge clk);
    check_val("handshake_errs", hs_err, 0);
    check_val("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
